// File: rtl/flood_it_pkg.sv
// Shared types and constants for the Flood-It game sequencer and its seed generator.
package flood_it_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GEN     = 3'd1,
        ST_GEN_ACK = 3'd2,
        ST_PLAY    = 3'd3,
        ST_FLOOD   = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam int COLOR_W    = 3;
    localparam int SIZE_W     = 5;
    localparam int CNUM_W     = 4;
    localparam int MOVE_W     = 6;
    localparam int SEED_W     = 16;
    localparam int MIN_SIZE   = 2;
    localparam int MIN_COLORS = 3;
    localparam int MAX_COLORS = 8;

    localparam logic [SEED_W-1:0] DEFAULT_SEED = 16'hDAD7;

endpackage

// File: rtl/seed_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16/14/13/11) supplying board seeds.
// An all-zero state can never advance, so it is replaced by the default seed.
module seed_lfsr
    import flood_it_pkg::*;
(
    input  logic              CLOCK,
    input  logic              RESET_N,
    output logic [SEED_W-1:0] lfsr_value
);

    logic [SEED_W-1:0] lfsr_q;
    logic              feedback;

    assign feedback   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_value = lfsr_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            lfsr_q <= DEFAULT_SEED;
        end else if (lfsr_q == '0) begin
            lfsr_q <= DEFAULT_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], feedback};
        end
    end

endmodule

// File: rtl/flood_game_ctrl.sv
// Flood-It game sequencer: latches settings, handshakes with the board generator,
// issues one flood-fill per legal colour press, counts moves and declares the result.
module flood_game_ctrl
    import flood_it_pkg::*;
#(
    parameter int MAX_SIZE    = 26,
    parameter int MOVE_SLACK  = 4,
    parameter int GEN_TIMEOUT = 4095
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               BTN_START,
    input  logic               BTN_COLOR_VLD,
    input  logic [COLOR_W-1:0] BTN_COLOR,
    input  logic [SIZE_W-1:0]  SIZE_SEL,
    input  logic [CNUM_W-1:0]  COLOR_NUM_SEL,
    input  logic [COLOR_W-1:0] CORNER_COLOR,
    output logic               NEW_BOARD,
    output logic [SEED_W-1:0]  SEED,
    output logic [SIZE_W-1:0]  SIZE,
    output logic [CNUM_W-1:0]  COLOR_NUM,
    input  logic               GEN_READY,
    output logic               FLOOD_START,
    output logic [COLOR_W-1:0] FLOOD_COLOR,
    input  logic               FLOOD_DONE,
    input  logic               FLOOD_UNIFORM,
    output logic [MOVE_W-1:0]  MOVES,
    output logic [MOVE_W-1:0]  MOVE_LIMIT,
    output logic [2:0]         STATE,
    output logic               WIN,
    output logic               LOSE,
    output logic               ERR
);

    localparam int TMR_W = $clog2(GEN_TIMEOUT + 1);

    function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] s);
        if (s < SIZE_W'(MIN_SIZE)) return SIZE_W'(MIN_SIZE);
        if (s > SIZE_W'(MAX_SIZE)) return SIZE_W'(MAX_SIZE);
        return s;
    endfunction

    function automatic logic [CNUM_W-1:0] clamp_colors(input logic [CNUM_W-1:0] c);
        if (c < CNUM_W'(MIN_COLORS)) return CNUM_W'(MIN_COLORS);
        if (c > CNUM_W'(MAX_COLORS)) return CNUM_W'(MAX_COLORS);
        return c;
    endfunction

    state_e             state_q, state_d;
    logic [SEED_W-1:0]  lfsr_value, seed_q;
    logic [SIZE_W-1:0]  size_q, size_clamped;
    logic [CNUM_W-1:0]  color_num_q, cnum_clamped;
    logic [COLOR_W-1:0] flood_color_q;
    logic [MOVE_W-1:0]  moves_q, move_limit_q;
    logic [TMR_W-1:0]   gen_tmr_q;
    logic               flood_start_q, win_q, lose_q, err_q, pending_q;
    logic               restart, accept, legal_press, tmr_inc;
    logic               set_win, set_lose, set_err, set_pending;

    seed_lfsr u_seed_lfsr (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .lfsr_value (lfsr_value)
    );

    assign size_clamped = clamp_size(SIZE_SEL);
    assign cnum_clamped = clamp_colors(COLOR_NUM_SEL);
    assign legal_press  = ({1'b0, BTN_COLOR} < color_num_q) && (BTN_COLOR != CORNER_COLOR);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        restart     = 1'b0;
        accept      = 1'b0;
        tmr_inc     = 1'b0;
        set_win     = 1'b0;
        set_lose    = 1'b0;
        set_err     = 1'b0;
        set_pending = 1'b0;
        case (state_q)
            ST_IDLE: restart = BTN_START;
            ST_GEN: begin
                if (GEN_READY) begin
                    state_d = ST_GEN_ACK;
                end else if (gen_tmr_q >= TMR_W'(GEN_TIMEOUT)) begin
                    set_err = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_GEN_ACK: if (!GEN_READY) state_d = ST_PLAY;
            ST_PLAY: begin
                if (BTN_START) begin
                    restart = 1'b1;
                end else if (BTN_COLOR_VLD && legal_press) begin
                    accept  = 1'b1;
                    state_d = ST_FLOOD;
                end
            end
            ST_FLOOD: begin
                // A restart requested mid-fill waits for the engine to finish, then skips scoring.
                if (FLOOD_DONE) begin
                    if (pending_q || BTN_START) begin
                        restart = 1'b1;
                    end else if (FLOOD_UNIFORM) begin
                        set_win = 1'b1;
                        state_d = ST_DONE;
                    end else if (moves_q == move_limit_q) begin
                        set_lose = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end else if (BTN_START) begin
                    set_pending = 1'b1;
                end
            end
            ST_DONE: restart = BTN_START;
            default: state_d = ST_IDLE;
        endcase
        if (restart) state_d = ST_GEN;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            seed_q        <= DEFAULT_SEED;
            size_q        <= SIZE_W'(14);
            color_num_q   <= CNUM_W'(6);
            move_limit_q  <= '0;
            moves_q       <= '0;
            flood_color_q <= '0;
            flood_start_q <= 1'b0;
            gen_tmr_q     <= '0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
            err_q         <= 1'b0;
            pending_q     <= 1'b0;
        end else begin
            flood_start_q <= accept;
            if (restart) begin
                size_q       <= size_clamped;
                color_num_q  <= cnum_clamped;
                seed_q       <= lfsr_value;
                move_limit_q <= MOVE_W'(size_clamped) + MOVE_W'(cnum_clamped) + MOVE_W'(MOVE_SLACK);
                moves_q      <= '0;
                gen_tmr_q    <= '0;
                win_q        <= 1'b0;
                lose_q       <= 1'b0;
                err_q        <= 1'b0;
                pending_q    <= 1'b0;
            end else begin
                if (accept) begin
                    flood_color_q <= BTN_COLOR;
                    if (moves_q != '1) moves_q <= moves_q + MOVE_W'(1);
                end
                if (tmr_inc)     gen_tmr_q <= gen_tmr_q + TMR_W'(1);
                if (set_win)     win_q     <= 1'b1;
                if (set_lose)    lose_q    <= 1'b1;
                if (set_err)     err_q     <= 1'b1;
                if (set_pending) pending_q <= 1'b1;
            end
        end
    end

    assign NEW_BOARD   = (state_q == ST_GEN);
    assign STATE       = state_q;
    assign SEED        = seed_q;
    assign SIZE        = size_q;
    assign COLOR_NUM   = color_num_q;
    assign MOVE_LIMIT  = move_limit_q;
    assign MOVES       = moves_q;
    assign FLOOD_START = flood_start_q;
    assign FLOOD_COLOR = flood_color_q;
    assign WIN         = win_q;
    assign LOSE        = lose_q;
    assign ERR         = err_q;

endmodule

// File: tb/tb_flood_game_ctrl.sv
// Scoreboard bench for flood_game_ctrl: stimulus queues expected events, a negedge
// monitor pops and checks them as the DUT produces board requests, fills and results.
module tb_flood_game_ctrl;

    localparam int S_IDLE = 0, S_GEN = 1, S_GEN_ACK = 2, S_PLAY = 3, S_FLOOD = 4, S_DONE = 5;
    localparam int EV_NB_RISE = 0, EV_NB_FALL = 1, EV_FSTART = 2, EV_WIN = 3, EV_LOSE = 4, EV_ERR = 5;

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
    } exp_t;

    logic        CLOCK, RESET_N;
    logic        BTN_START, BTN_COLOR_VLD;
    logic [2:0]  BTN_COLOR, CORNER_COLOR, FLOOD_COLOR;
    logic [4:0]  SIZE_SEL, SIZE;
    logic [3:0]  COLOR_NUM_SEL, COLOR_NUM;
    logic        NEW_BOARD, GEN_READY, FLOOD_START, FLOOD_DONE, FLOOD_UNIFORM;
    logic [15:0] SEED;
    logic [5:0]  MOVES, MOVE_LIMIT;
    logic [2:0]  STATE;
    logic        WIN, LOSE, ERR;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    bit          gen_en = 1'b1;
    logic [15:0] m_lfsr, m_prev;

    flood_game_ctrl dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .BTN_START(BTN_START), .BTN_COLOR_VLD(BTN_COLOR_VLD),
        .BTN_COLOR(BTN_COLOR), .SIZE_SEL(SIZE_SEL), .COLOR_NUM_SEL(COLOR_NUM_SEL),
        .CORNER_COLOR(CORNER_COLOR), .NEW_BOARD(NEW_BOARD), .SEED(SEED), .SIZE(SIZE),
        .COLOR_NUM(COLOR_NUM), .GEN_READY(GEN_READY), .FLOOD_START(FLOOD_START),
        .FLOOD_COLOR(FLOOD_COLOR), .FLOOD_DONE(FLOOD_DONE), .FLOOD_UNIFORM(FLOOD_UNIFORM),
        .MOVES(MOVES), .MOVE_LIMIT(MOVE_LIMIT), .STATE(STATE), .WIN(WIN), .LOSE(LOSE), .ERR(ERR)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        if (x == 16'h0) return 16'hDAD7;
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    // Reference seed sequence; m_prev holds the value present during the previous cycle.
    always @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_lfsr <= 16'hDAD7;
            m_prev <= 16'hDAD7;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic expect_ev(input int kind, input int a, input int b, input int c);
        exp_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic pop_ev(input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        e.kind = -1; e.a = 0; e.b = 0; e.c = 0;
        n_chk++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got event %0d, expected none (t=%0t)", kind, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind) begin
                n_pass++;
                ok = 1'b1;
            end else begin
                $display("FAIL event_order: got event %0d, expected event %0d (t=%0t)", kind, e.kind, $time);
            end
        end
    endtask

    // Generator model: READY 50 cycles into a request, dropped once NEW_BOARD falls.
    initial begin
        int cnt;
        cnt = 0;
        GEN_READY = 1'b0;
        forever begin
            @(posedge CLOCK);
            #1;
            if (!RESET_N || !NEW_BOARD) begin
                cnt = 0;
                GEN_READY = 1'b0;
            end else if (gen_en) begin
                cnt++;
                if (cnt >= 50) GEN_READY = 1'b1;
            end
        end
    end

    // Monitor.
    initial begin
        logic        p_nb, p_fs, p_win, p_lose, p_err;
        logic [15:0] rise_seed;
        int          nb_len, run, last_run;
        exp_t        e;
        bit          ok;
        p_nb = 0; p_fs = 0; p_win = 0; p_lose = 0; p_err = 0;
        rise_seed = 0; nb_len = 0; run = 0; last_run = 0;
        forever begin
            @(negedge CLOCK);
            if (!RESET_N) begin
                p_nb = 0; p_fs = 0; p_win = 0; p_lose = 0; p_err = 0;
                nb_len = 0; run = 0; last_run = 0;
            end else begin
                if (GEN_READY) run++;
                else begin
                    if (run != 0) last_run = run;
                    run = 0;
                end
                if (NEW_BOARD && !p_nb) begin
                    pop_ev(EV_NB_RISE, e, ok);
                    if (ok) begin
                        chk("size", SIZE, e.a);
                        chk("color_num", COLOR_NUM, e.b);
                        chk("move_limit", MOVE_LIMIT, e.c);
                        chk("moves_clear", MOVES, 0);
                        chk("seed", SEED, m_prev);
                    end
                    rise_seed = SEED;
                    nb_len = 0;
                    last_run = 0;
                end
                if (NEW_BOARD) nb_len++;
                if (!NEW_BOARD && p_nb) begin
                    pop_ev(EV_NB_FALL, e, ok);
                    if (ok) begin
                        chk("new_board_len", nb_len, e.a);
                        chk("seed_stable", SEED, rise_seed);
                        if (e.b != 0) chk("fall_after_ready", last_run, 1);
                    end
                end
                if (p_fs) chk("flood_start_pulse", FLOOD_START, 0);
                if (FLOOD_START && !p_fs) begin
                    pop_ev(EV_FSTART, e, ok);
                    if (ok) begin
                        chk("flood_color", FLOOD_COLOR, e.a);
                        chk("moves", MOVES, e.b);
                    end
                end
                if (WIN && !p_win) begin
                    pop_ev(EV_WIN, e, ok);
                    if (ok) chk("win_moves", MOVES, e.a);
                end
                if (LOSE && !p_lose) begin
                    pop_ev(EV_LOSE, e, ok);
                    if (ok) chk("lose_moves", MOVES, e.a);
                end
                if (ERR && !p_err) begin
                    pop_ev(EV_ERR, e, ok);
                    if (ok) chk("err_state", STATE, S_IDLE);
                end
                p_nb = NEW_BOARD; p_fs = FLOOD_START; p_win = WIN; p_lose = LOSE; p_err = ERR;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic pulse_start(input int sz, input int cn);
        SIZE_SEL = 5'(sz);
        COLOR_NUM_SEL = 4'(cn);
        BTN_START = 1'b1;
        tick(1);
        BTN_START = 1'b0;
    endtask

    task automatic press(input int c);
        BTN_COLOR = 3'(c);
        BTN_COLOR_VLD = 1'b1;
        tick(1);
        BTN_COLOR_VLD = 1'b0;
    endtask

    task automatic flood_done(input bit uniform);
        FLOOD_DONE = 1'b1;
        FLOOD_UNIFORM = uniform;
        tick(1);
        FLOOD_DONE = 1'b0;
        FLOOD_UNIFORM = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int i;
        i = 0;
        while (STATE !== 3'(s) && i < budget) begin
            tick(1);
            i++;
        end
        chk(name, STATE, s);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, STATE, S_IDLE);
        chk({tag, "_new_board"}, NEW_BOARD, 0);
        chk({tag, "_flood_start"}, FLOOD_START, 0);
        chk({tag, "_flood_color"}, FLOOD_COLOR, 0);
        chk({tag, "_seed"}, SEED, 16'hDAD7);
        chk({tag, "_size"}, SIZE, 14);
        chk({tag, "_color_num"}, COLOR_NUM, 6);
        chk({tag, "_moves"}, MOVES, 0);
        chk({tag, "_move_limit"}, MOVE_LIMIT, 0);
        chk({tag, "_flags"}, {WIN, LOSE, ERR}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET_N = 1'b0;
        BTN_START = 0; BTN_COLOR_VLD = 0; BTN_COLOR = 0;
        SIZE_SEL = 0; COLOR_NUM_SEL = 0; CORNER_COLOR = 3'd2;
        FLOOD_DONE = 0; FLOOD_UNIFORM = 0;
        tick(3);
        chk_reset_outputs("reset");
        RESET_N = 1'b1;
        tick(2);

        // Clamped settings, generator handshake.
        expect_ev(EV_NB_RISE, 2, 8, 14);
        expect_ev(EV_NB_FALL, 50, 1, 0);
        pulse_start(1, 9);
        chk("new_board_next_cycle", NEW_BOARD, 1);
        wait_state(S_GEN_ACK, 100, "reach_gen_ack");
        wait_state(S_PLAY, 10, "reach_play_1");

        // START with a simultaneous legal colour press restarts; no fill issued.
        expect_ev(EV_NB_RISE, 2, 4, 10);
        expect_ev(EV_NB_FALL, 50, 1, 0);
        BTN_COLOR = 3'd1;
        BTN_COLOR_VLD = 1'b1;
        pulse_start(2, 4);
        BTN_COLOR_VLD = 1'b0;
        chk("start_wins_state", STATE, S_GEN);
        wait_state(S_PLAY, 100, "reach_play_2");

        // Illegal presses ignored, legal press fills, presses during fill dropped.
        press(5);
        press(2);
        chk("ignored_moves", MOVES, 0);
        chk("ignored_state", STATE, S_PLAY);
        expect_ev(EV_FSTART, 1, 1, 0);
        press(1);
        chk("accept_state", STATE, S_FLOOD);
        press(0);
        chk("flood_drop_moves", MOVES, 1);
        flood_done(1'b0);
        chk("back_to_play", STATE, S_PLAY);

        // Lose after reaching the move limit of 2+3+4.
        CORNER_COLOR = 3'd0;
        expect_ev(EV_NB_RISE, 2, 3, 9);
        expect_ev(EV_NB_FALL, 50, 1, 0);
        pulse_start(2, 3);
        wait_state(S_PLAY, 100, "reach_play_3");
        for (int i = 1; i <= 9; i++) begin
            expect_ev(EV_FSTART, 1, i, 0);
            press(1);
            if (i == 9) expect_ev(EV_LOSE, 9, 0, 0);
            flood_done(1'b0);
        end
        chk("lose_state", STATE, S_DONE);
        chk("lose_flag", LOSE, 1);

        // Win on the third move.
        expect_ev(EV_NB_RISE, 2, 3, 9);
        expect_ev(EV_NB_FALL, 50, 1, 0);
        pulse_start(2, 3);
        chk("lose_cleared", LOSE, 0);
        wait_state(S_PLAY, 100, "reach_play_4");
        for (int i = 1; i <= 3; i++) begin
            expect_ev(EV_FSTART, 1, i, 0);
            press(1);
            if (i == 3) expect_ev(EV_WIN, 3, 0, 0);
            flood_done(i == 3);
        end
        chk("win_state", STATE, S_DONE);
        chk("win_flag", WIN, 1);

        // START during a fill is deferred until FLOOD_DONE and suppresses the result.
        expect_ev(EV_NB_RISE, 2, 3, 9);
        expect_ev(EV_NB_FALL, 50, 1, 0);
        pulse_start(2, 3);
        wait_state(S_PLAY, 100, "reach_play_5");
        expect_ev(EV_FSTART, 1, 1, 0);
        press(1);
        pulse_start(7, 5);
        tick(3);
        chk("pending_no_board", NEW_BOARD, 0);
        chk("pending_state", STATE, S_FLOOD);
        expect_ev(EV_NB_RISE, 7, 5, 16);
        expect_ev(EV_NB_FALL, 50, 1, 0);
        flood_done(1'b1);
        chk("pending_restart_state", STATE, S_GEN);
        chk("pending_flags", {WIN, LOSE}, 0);
        wait_state(S_PLAY, 100, "reach_play_6");

        // Asynchronous reset in the middle of a fill.
        expect_ev(EV_FSTART, 1, 1, 0);
        press(1);
        tick(1);
        #3;
        RESET_N = 1'b0;
        #1;
        chk_reset_outputs("midflood");
        tick(2);
        RESET_N = 1'b1;
        tick(2);

        // Generator never answers: abort after the timeout.
        gen_en = 1'b0;
        expect_ev(EV_NB_RISE, 26, 6, 36);
        expect_ev(EV_NB_FALL, 4096, 0, 0);
        expect_ev(EV_ERR, 0, 0, 0);
        pulse_start(31, 6);
        wait_state(S_IDLE, 5000, "timeout_idle");
        chk("timeout_err", ERR, 1);
        chk("timeout_new_board", NEW_BOARD, 0);

        gen_en = 1'b1;
        expect_ev(EV_NB_RISE, 2, 3, 9);
        expect_ev(EV_NB_FALL, 50, 1, 0);
        pulse_start(0, 2);
        chk("err_cleared", ERR, 0);
        wait_state(S_PLAY, 100, "reach_play_7");

        tick(5);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
